// File: rtl/branch_predict_unit.sv
// Branch resolution and BTB-based next-PC prediction.
// Direct-mapped BTB with 2-bit counters; EX resolution drives a registered redirect.
module branch_predict_unit #(
  parameter int XLEN      = 32,
  parameter int BTB_DEPTH = 16,
  parameter int OP_W      = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic            ex_stall,
  input  logic [OP_W-1:0] alu_op,
  input  logic [XLEN-1:0] reg_data1,
  input  logic [XLEN-1:0] reg_data2,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            flush,
  output logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] link_addr,
  output logic [31:0]     br_count,
  output logic [31:0]     mispred_count
);

  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = XLEN - IDX_W - 2;

  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b001011);
  localparam logic [OP_W-1:0] OP_BLT  = OP_W'(6'b001100);
  localparam logic [OP_W-1:0] OP_BGE  = OP_W'(6'b001101);
  localparam logic [OP_W-1:0] OP_JAL  = OP_W'(6'b001110);
  localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6'b001111);
  localparam logic [OP_W-1:0] OP_BLTU = OP_W'(6'b010000);
  localparam logic [OP_W-1:0] OP_BGEU = OP_W'(6'b010001);
  localparam logic [OP_W-1:0] OP_JALR = OP_W'(6'b010010);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

  logic             r_valid  [BTB_DEPTH];
  logic [TAG_W-1:0] r_tag    [BTB_DEPTH];
  logic [XLEN-1:0]  r_target [BTB_DEPTH];
  logic [1:0]       r_ctr    [BTB_DEPTH];

  logic            r_flush;
  logic [XLEN-1:0] r_redirect_pc;
  logic [31:0]     r_br_count;
  logic [31:0]     r_mispred_count;

  logic [IDX_W-1:0] w_if_idx;
  logic [TAG_W-1:0] w_if_tag;
  logic             w_if_hit;
  logic [IDX_W-1:0] w_ex_idx;
  logic [TAG_W-1:0] w_ex_tag;
  logic             w_ex_hit;

  logic            w_is_br;
  logic            w_is_jal;
  logic            w_is_jalr;
  logic            w_br_taken;
  logic            w_is_jump;
  logic            w_is_ctrl;
  logic            w_taken;
  logic [XLEN-1:0] w_br_target;
  logic [XLEN-1:0] w_jalr_sum;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_fallthru;
  logic [XLEN-1:0] w_redirect;
  logic            w_mispred;
  logic            w_resolve;
  logic            w_write;
  logic [1:0]      w_ctr_cur;
  logic [1:0]      w_ctr_next;

  // Fetch-side lookup reads the pre-update array, giving read-before-write for free.
  assign w_if_idx    = if_pc[IDX_W+1:2];
  assign w_if_tag    = if_pc[XLEN-1:IDX_W+2];
  assign w_if_hit    = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
  assign pred_taken  = w_if_hit && r_ctr[w_if_idx][1];
  assign pred_target = w_if_hit ? r_target[w_if_idx] : (if_pc + PC_STEP);

  assign w_ex_idx  = ex_pc[IDX_W+1:2];
  assign w_ex_tag  = ex_pc[XLEN-1:IDX_W+2];
  assign w_ex_hit  = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
  assign w_ctr_cur = r_ctr[w_ex_idx];

  // Opcode decode and branch condition evaluation.
  always_comb begin
    w_is_br    = 1'b0;
    w_is_jal   = 1'b0;
    w_is_jalr  = 1'b0;
    w_br_taken = 1'b0;
    case (alu_op)
      OP_BEQ:  begin w_is_br = 1'b1; w_br_taken = (reg_data1 == reg_data2); end
      OP_BNE:  begin w_is_br = 1'b1; w_br_taken = (reg_data1 != reg_data2); end
      OP_BLT:  begin w_is_br = 1'b1; w_br_taken = ($signed(reg_data1) <  $signed(reg_data2)); end
      OP_BGE:  begin w_is_br = 1'b1; w_br_taken = ($signed(reg_data1) >= $signed(reg_data2)); end
      OP_BLTU: begin w_is_br = 1'b1; w_br_taken = (reg_data1 <  reg_data2); end
      OP_BGEU: begin w_is_br = 1'b1; w_br_taken = (reg_data1 >= reg_data2); end
      OP_JAL:  w_is_jal  = 1'b1;
      OP_JALR: w_is_jalr = 1'b1;
      default: begin
        w_is_br    = 1'b0;
        w_br_taken = 1'b0;
      end
    endcase
  end

  assign w_is_jump   = w_is_jal || w_is_jalr;
  assign w_is_ctrl   = w_is_br || w_is_jump;
  assign w_taken     = w_is_jump || w_br_taken;
  assign w_br_target = ex_pc + imm;
  assign w_jalr_sum  = reg_data1 + imm;
  assign w_target    = w_is_jalr ? {w_jalr_sum[XLEN-1:1], 1'b0} : w_br_target;
  assign w_fallthru  = ex_pc + PC_STEP;
  assign w_redirect  = w_taken ? w_target : w_fallthru;
  assign link_addr   = w_fallthru;

  assign w_mispred = (w_taken != ex_pred_taken) || (w_taken && (ex_pred_target != w_target));
  // The instruction in EX during a flush cycle is wrong-path and must not resolve.
  assign w_resolve = ex_valid && !ex_stall && !r_flush && w_is_ctrl;
  assign w_write   = w_resolve && (w_ex_hit || w_taken);

  // Next counter value: jumps pin to strong-taken, new branches start weak-taken.
  always_comb begin
    w_ctr_next = w_ctr_cur;
    if (w_is_jump) begin
      w_ctr_next = 2'b11;
    end else if (!w_ex_hit) begin
      w_ctr_next = 2'b10;
    end else if (w_taken) begin
      w_ctr_next = (w_ctr_cur == 2'b11) ? 2'b11 : (w_ctr_cur + 2'd1);
    end else begin
      w_ctr_next = (w_ctr_cur == 2'b00) ? 2'b00 : (w_ctr_cur - 2'd1);
    end
  end

  // BTB storage: clear on reset, otherwise train on resolution.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b01;
      end
    end else if (w_write) begin
      r_valid[w_ex_idx] <= 1'b1;
      r_tag[w_ex_idx]   <= w_ex_tag;
      r_ctr[w_ex_idx]   <= w_ctr_next;
      if (w_taken) begin
        r_target[w_ex_idx] <= w_target;
      end
    end
  end

  // Redirect strobe, corrected PC and statistics.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_flush         <= 1'b0;
      r_redirect_pc   <= '0;
      r_br_count      <= 32'd0;
      r_mispred_count <= 32'd0;
    end else begin
      r_flush <= w_resolve && w_mispred;
      if (w_resolve) begin
        r_br_count <= r_br_count + 32'd1;
        if (w_mispred) begin
          r_mispred_count <= r_mispred_count + 32'd1;
          r_redirect_pc   <= w_redirect;
        end
      end
    end
  end

  assign flush         = r_flush;
  assign redirect_pc   = r_redirect_pc;
  assign br_count      = r_br_count;
  assign mispred_count = r_mispred_count;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed scenarios then random traffic
// checked against an entry-level behavioural BTB model.
module tb_branch_predict_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic        ex_stall;
  logic [5:0]  alu_op;
  logic [31:0] reg_data1;
  logic [31:0] reg_data2;
  logic [31:0] imm;
  logic [31:0] ex_pc;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [31:0] link_addr;
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  branch_predict_unit dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .ex_valid(ex_valid), .ex_stall(ex_stall),
    .alu_op(alu_op), .reg_data1(reg_data1), .reg_data2(reg_data2), .imm(imm),
    .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .flush(flush), .redirect_pc(redirect_pc), .link_addr(link_addr),
    .br_count(br_count), .mispred_count(mispred_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: one record per BTB slot, plus architectural outputs.
  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  bit          m_flush;
  logic [31:0] m_redir;
  logic [31:0] m_br;
  logic [31:0] m_mis;
  bit          m_known = 1'b0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  function automatic int slot(input logic [31:0] pc);
    return int'((pc / 32'd4) % 32'd16);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[slot(pc)] && (m_tag[slot(pc)] == pc / 32'd64);
  endfunction

  function automatic bit m_pred_taken(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[slot(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_pred_target(input logic [31:0] pc);
    return m_hit(pc) ? m_tgt[slot(pc)] : pc + 32'd4;
  endfunction

  // Advance the model across one rising edge using the inputs currently applied.
  task automatic model_edge();
    int op;
    bit is_j, is_b, taken, resolve, mis, hit;
    logic [31:0] tgt;
    int s;
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[i] = 1'b0;
        m_ctr[i]   = 1;
      end
      m_flush = 1'b0;
      m_redir = 32'd0;
      m_br    = 32'd0;
      m_mis   = 32'd0;
      m_known = 1'b1;
    end else begin
      op    = int'(alu_op);
      is_j  = (op == 14) || (op == 18);
      is_b  = (op == 11) || (op == 12) || (op == 13) || (op == 15) || (op == 16) || (op == 17);
      taken = 1'b0;
      case (op)
        11: taken = (reg_data1 == reg_data2);
        15: taken = (reg_data1 != reg_data2);
        12: taken = int'(reg_data1) <  int'(reg_data2);
        13: taken = int'(reg_data1) >= int'(reg_data2);
        16: taken = (reg_data1 <  reg_data2);
        17: taken = (reg_data1 >= reg_data2);
        14, 18: taken = 1'b1;
        default: taken = 1'b0;
      endcase
      tgt     = (op == 18) ? ((reg_data1 + imm) & 32'hFFFF_FFFE) : (ex_pc + imm);
      resolve = ex_valid && !ex_stall && !m_flush && (is_j || is_b);
      mis     = (taken != ex_pred_taken) || (taken && (ex_pred_target != tgt));
      hit     = m_hit(ex_pc);
      s       = slot(ex_pc);
      m_flush = resolve && mis;
      if (resolve) begin
        m_br = m_br + 32'd1;
        if (mis) begin
          m_mis   = m_mis + 32'd1;
          m_redir = taken ? tgt : ex_pc + 32'd4;
        end
        if (hit || taken) begin
          if (is_j)       m_ctr[s] = 3;
          else if (!hit)  m_ctr[s] = 2;
          else if (taken) m_ctr[s] = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
          else            m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
          if (taken) m_tgt[s] = tgt;
          m_valid[s] = 1'b1;
          m_tag[s]   = ex_pc / 32'd64;
        end
      end
    end
  endtask

  // One clock: check combinational outputs, cross the edge, check registered outputs.
  task automatic step();
    #4;
    if (m_known) begin
      chk("pred_taken", {31'd0, pred_taken}, {31'd0, m_pred_taken(if_pc)});
      chk("pred_target", pred_target, m_pred_target(if_pc));
    end
    chk("link_addr", link_addr, ex_pc + 32'd4);
    @(posedge clk);
    model_edge();
    #1;
    chk("flush", {31'd0, flush}, {31'd0, m_flush});
    chk("redirect_pc", redirect_pc, m_redir);
    chk("br_count", br_count, m_br);
    chk("mispred_count", mispred_count, m_mis);
  endtask

  task automatic set_idle();
    ex_valid = 1'b0; ex_stall = 1'b0; alu_op = 6'd0;
    reg_data1 = 32'd0; reg_data2 = 32'd0; imm = 32'd0; ex_pc = 32'd0;
    ex_pred_taken = 1'b0; ex_pred_target = 32'd0;
  endtask

  task automatic set_op(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] im, input logic pt,
                        input logic [31:0] ptg);
    ex_valid = 1'b1; ex_stall = 1'b0; alu_op = op; ex_pc = pc;
    reg_data1 = r1; reg_data2 = r2; imm = im; ex_pred_taken = pt; ex_pred_target = ptg;
  endtask

  logic [31:0] br_before;
  logic [31:0] mis_before;
  logic [31:0] redir_before;

  initial begin
    rst_n = 1'b0; if_pc = 32'h100;
    set_idle();
    step();
    step();
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_br_count", br_count, 32'd0);
    rst_n = 1'b1;
    step();

    // BEQ taken while predicted not-taken, then the trained entry predicts.
    set_op(6'd11, 32'h100, 32'd5, 32'd5, 32'h20, 1'b0, 32'h104);
    step();
    chk("beq_flush", {31'd0, flush}, 32'd1);
    chk("beq_redirect", redirect_pc, 32'h120);
    chk("beq_mispred", mispred_count, 32'd1);
    set_idle(); if_pc = 32'h100;
    #1;
    chk("beq_pred_taken", {31'd0, pred_taken}, 32'd1);
    chk("beq_pred_target", pred_target, 32'h120);
    step();

    // Signed vs unsigned compare of 0xFFFFFFFF against 1.
    set_op(6'd12, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0, 32'h204);
    step();
    chk("blt_taken_redirect", redirect_pc, 32'h240);
    set_idle(); step();
    set_op(6'd16, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b1, 32'h340);
    step();
    chk("bltu_flush", {31'd0, flush}, 32'd1);
    chk("bltu_redirect", redirect_pc, 32'h304);
    set_idle(); step();

    // JALR: target bit 0 cleared; correct prediction then wrong target.
    set_op(6'd18, 32'h400, 32'h203, 32'd0, 32'd0, 1'b1, 32'h202);
    step();
    chk("jalr_ok_flush", {31'd0, flush}, 32'd0);
    set_idle(); if_pc = 32'h400; step();
    chk("jalr_pred", {31'd0, m_pred_taken(32'h400)}, 32'd1);
    set_op(6'd18, 32'h400, 32'h203, 32'd0, 32'd0, 1'b1, 32'h200);
    step();
    chk("jalr_bad_flush", {31'd0, flush}, 32'd1);
    chk("jalr_bad_redirect", redirect_pc, 32'h202);
    set_idle(); step();

    // Counter saturation: allocate, four not-taken, one taken.
    set_op(6'd15, 32'h500, 32'd1, 32'd2, 32'h10, 1'b0, 32'h504);
    step(); set_idle(); step();
    for (int k = 0; k < 4; k++) begin
      set_op(6'd15, 32'h500, 32'd3, 32'd3, 32'h10, m_pred_taken(32'h500), m_pred_target(32'h500));
      step(); set_idle(); step();
    end
    if_pc = 32'h500; #1;
    chk("sat_low_pred", {31'd0, pred_taken}, 32'd0);
    set_op(6'd15, 32'h500, 32'd1, 32'd2, 32'h10, 1'b0, 32'h504);
    step(); set_idle(); if_pc = 32'h500; #1;
    chk("after_one_taken_pred", {31'd0, pred_taken}, 32'd0);
    step();

    // Wrong-path instruction in the flush cycle, then a stalled mispredict.
    br_before = m_br;
    set_op(6'd11, 32'h700, 32'd9, 32'd9, 32'h8, 1'b0, 32'h704);
    step();
    chk("wp_first_flush", {31'd0, flush}, 32'd1);
    set_op(6'd15, 32'h740, 32'd1, 32'd2, 32'h8, 1'b0, 32'h744);
    step();
    chk("wp_ignored_flush", {31'd0, flush}, 32'd0);
    chk("wp_br_once", br_count, br_before + 32'd1);
    br_before = br_count; mis_before = mispred_count; redir_before = redirect_pc;
    set_op(6'd11, 32'h780, 32'd4, 32'd4, 32'h8, 1'b0, 32'h784);
    ex_stall = 1'b1;
    step();
    chk("stall_flush", {31'd0, flush}, 32'd0);
    chk("stall_br", br_count, br_before);
    chk("stall_mis", mispred_count, mis_before);
    chk("stall_redirect", redirect_pc, redir_before);

    // Reset overrides a simultaneous resolution.
    set_op(6'd14, 32'h600, 32'd0, 32'd0, 32'h40, 1'b0, 32'h604);
    rst_n = 1'b0;
    step();
    chk("rst_res_br", br_count, 32'd0);
    chk("rst_res_redirect", redirect_pc, 32'd0);
    chk("rst_res_flush", {31'd0, flush}, 32'd0);
    rst_n = 1'b1; set_idle(); if_pc = 32'h600; #1;
    chk("rst_res_pred", {31'd0, pred_taken}, 32'd0);
    chk("rst_res_target", pred_target, 32'h604);
    step();

    // Random traffic over a few aliasing tags.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] pc;
      logic [5:0]  op;
      pc = 32'h1000 + ($urandom_range(0, 2) << 6) + ($urandom_range(0, 15) << 2);
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : 6'(11 + $urandom_range(0, 7));
      set_op(op, pc,
             ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom(),
             ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom(),
             32'($urandom_range(0, 255)) - 32'd128,
             1'b0, 32'd0);
      if ($urandom_range(0, 1) == 1) begin
        ex_pred_taken = m_pred_taken(pc); ex_pred_target = m_pred_target(pc);
      end else begin
        ex_pred_taken = 1'($urandom_range(0, 1)); ex_pred_target = $urandom();
      end
      ex_valid = ($urandom_range(0, 4) != 0);
      ex_stall = ($urandom_range(0, 6) == 0);
      rst_n    = ($urandom_range(0, 99) != 0);
      if_pc    = 32'h1000 + ($urandom_range(0, 2) << 6) + ($urandom_range(0, 15) << 2);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
